// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index of the set bit in a one-hot vector (up to 32 channels); 0 when empty.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: owns the search pointer and produces a one-hot grant.
module rr_arbiter #(
  parameter  int N_CH  = 3,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             advance,
  input  logic [SEL_W-1:0] adv_idx,
  output logic [N_CH-1:0]  grant
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] idx;
  logic             found;

  // Pointer moves just past the channel that last transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (adv_idx == SEL_W'(N_CH - 1)) ? '0 : adv_idx + SEL_W'(1);
    end
  end

  // Search ptr, ptr+1, ... with wrap; first requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = SEL_W'((int'(ptr) + k) % N_CH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-select and round-robin modes
// and a single registered output stage running at one beat per cycle.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 3,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  logic              load_en;
  logic [N_CH-1:0]   grant_fix;
  logic [N_CH-1:0]   grant_rr;
  logic [N_CH-1:0]   grant;
  logic              xfer;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_data;
  logic [31:0]       grant_ext;

  assign load_en = !out_valid || out_ready;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (xfer && (mode == MODE_RR)),
    .adv_idx (grant_idx),
    .grant   (grant_rr)
  );

  // Fixed-select grant; an out-of-range select yields no grant at all.
  always_comb begin
    grant_fix = '0;
    if (int'(sel) < N_CH) begin
      grant_fix[sel] = in_valid[sel];
    end
  end

  // Pick the active grant, gate with load_en and reset, and steer the data.
  always_comb begin
    grant      = (mode == MODE_RR) ? grant_rr : grant_fix;
    in_ready   = grant & {N_CH{load_en && rst_n}};
    xfer       = |in_ready;
    grant_ext  = '0;
    grant_ext[N_CH-1:0] = grant;
    grant_idx  = SEL_W'(onehot_to_idx(grant_ext));
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register: load on a transfer, drop valid when idle, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= grant_data;
        out_ch   <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N_CH=3, WIDTH=8).
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [2:0]  in_valid;
  logic [23:0] in_data;
  logic [2:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic       mode;
    logic [1:0] sel;
    logic [2:0] valid;
    logic [2:0] exp_rdy;
  } vec_t;
  vec_t tbl[17];

  logic [7:0] dat [3];

  stream_mux_rr #(.N_CH(3), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data();
    in_data = {dat[2], dat[1], dat[0]};
  endtask

  // Compare the output register against the oldest scoreboard entry.
  task automatic pop_check(input string name);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: output beat ch=%0d data=%0h with nothing expected", name, out_ch, out_data);
    end else begin
      total--;
      e = sb.pop_front();
      chk({name, "_data"}, 32'(out_data), 32'(e.data));
      chk({name, "_ch"}, 32'(out_ch), 32'(e.ch));
    end
  endtask

  // One cycle with out_ready=1: check in_ready, push expected beat, check output.
  task automatic step(input logic m, input logic [1:0] s, input logic [2:0] v,
                      input logic [2:0] exp_rdy, input string name);
    int ch;
    mode = m; sel = s; in_valid = v; out_ready = 1'b1;
    #1;
    chk({name, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy != 3'b000) begin
      ch = (exp_rdy == 3'b001) ? 0 : (exp_rdy == 3'b010) ? 1 : 2;
      sb.push_back('{data: dat[ch], ch: 2'(ch)});
    end
    @(posedge clk); #1;
    chk({name, "_out_valid"}, 32'(out_valid), 32'(exp_rdy != 3'b000));
    if (out_valid) pop_check(name);
  endtask

  initial begin
    // mode, sel, in_valid, expected in_ready
    tbl[0]  = '{1'b1, 2'd0, 3'b111, 3'b001};  // RR after reset starts at ch0
    tbl[1]  = '{1'b0, 2'd2, 3'b111, 3'b100};  // fixed sel=2
    tbl[2]  = '{1'b0, 2'd2, 3'b111, 3'b100};
    tbl[3]  = '{1'b0, 2'd3, 3'b111, 3'b000};  // illegal sel
    tbl[4]  = '{1'b0, 2'd1, 3'b010, 3'b010};
    tbl[5]  = '{1'b0, 2'd0, 3'b110, 3'b000};  // selected channel not valid
    tbl[6]  = '{1'b1, 2'd0, 3'b111, 3'b010};  // ptr held at 1 through fixed mode
    tbl[7]  = '{1'b1, 2'd0, 3'b111, 3'b100};
    tbl[8]  = '{1'b1, 2'd0, 3'b111, 3'b001};
    tbl[9]  = '{1'b1, 2'd0, 3'b111, 3'b010};
    tbl[10] = '{1'b1, 2'd0, 3'b101, 3'b100};
    tbl[11] = '{1'b1, 2'd0, 3'b101, 3'b001};
    tbl[12] = '{1'b1, 2'd0, 3'b101, 3'b100};
    tbl[13] = '{1'b1, 2'd0, 3'b000, 3'b000};
    tbl[14] = '{1'b1, 2'd0, 3'b110, 3'b010};
    tbl[15] = '{1'b1, 2'd0, 3'b011, 3'b001};  // wrap from ptr=2 to ch0
    tbl[16] = '{1'b0, 2'd2, 3'b011, 3'b000};

    dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'hC3;
    set_data();
    mode = 1'b1; sel = 2'd0; in_valid = 3'b111; out_ready = 1'b1;
    rst_n = 1'b0;

    // Reset held across edges with all channels requesting.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].exp_rdy, $sformatf("vec%0d", i));
    end

    // Backpressure: ptr=1, load 0x5A from ch1, then stall for 4 cycles.
    dat[1] = 8'h5A;
    set_data();
    step(1'b1, 2'd0, 3'b010, 3'b010, "bp_load");
    in_valid = 3'b111; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_data", c), 32'(out_data), 32'h5A);
      chk($sformatf("bp%0d_ch", c), 32'(out_ch), 32'd1);
    end
    step(1'b1, 2'd0, 3'b111, 3'b100, "bp_release");

    // Mid-stream asynchronous reset between edges.
    step(1'b1, 2'd0, 3'b111, 3'b001, "pre_rst0");
    step(1'b1, 2'd0, 3'b111, 3'b010, "pre_rst1");
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_ch", 32'(out_ch), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'b001);
    sb.push_back('{data: dat[0], ch: 2'd0});
    @(posedge clk); #1;
    chk("postrst_out_valid", 32'(out_valid), 32'd1);
    if (out_valid) pop_check("postrst");
    step(1'b1, 2'd0, 3'b111, 3'b010, "postrst_next");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
